booth_arbiter: RTL and testbench
================================

BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width; the product is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles allowed for booth_dv.
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  requester 0 / 1 operation request, level, held until its grant.
- a0 / a1  in  WIDTH  requester multiplier, signed, stable while req is high.
- b0 / b1  in  WIDTH  requester multiplicand, signed, stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, operands latched.
- done  out  1  one-cycle pulse: result valid.
- done_id  out  1  requester owning the current done.
- result  out  2*WIDTH  signed product, valid with done.
- timeout  out  1  valid with done: booth_dv never arrived, result forced to 0.
- load  out  1  load strobe to the shared Booth multiplier.
- Multiplier / Multiplicand  out  WIDTH  operands to the shared multiplier.
- Product  in  2*WIDTH  product from the shared multiplier.
- booth_dv  in  1  product-valid flag from the shared multiplier.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have four states: IDLE, LOAD, WAIT, RESP.
REQ-006 IDLE with no request: stay in IDLE, all outputs 0.
REQ-007 IDLE with at least one request at edge N: select a winner; latch its operands into Multiplier/Multiplicand; drive the winner's gnt high for exactly the cycle after edge N; go to LOAD.
REQ-008 Arbitration SHALL be round-robin: a single requesting side wins; when both request, the side named by the priority pointer wins.
REQ-009 The priority pointer SHALL move to the non-winner on the RESP -> IDLE transition.
REQ-010 LOAD: assert load for exactly one cycle; go to WAIT.
REQ-011 WAIT: hold load at 0.
- booth_dv is ignored on the first WAIT cycle (stale-flag guard).
- From the second WAIT cycle, booth_dv=1 captures Product into result and goes to RESP.
REQ-012 WAIT cycles SHALL be counted; when the count reaches TIMEOUT with no qualifying booth_dv, go to RESP with timeout=1 and result=0.
REQ-013 RESP: done=1, done_id=owner and timeout valid for exactly one cycle; go to IDLE.
REQ-014 result and done_id SHALL hold until the next done; timeout SHALL clear after the done cycle.
REQ-015 Multiplier/Multiplicand SHALL stay constant from LOAD until the next grant.
REQ-016 Best-case latency, request sampled at edge N to done high: cycle after edge N+3 (LOAD, WAIT x2, RESP).
REQ-017 Requests arriving outside IDLE SHALL remain pending and are arbitrated on the next IDLE cycle.
REQ-018 A request deasserted before its grant SHALL be dropped with no response.
REQ-019 Requests SHALL never be accepted back-to-back without an intervening IDLE cycle.
REQ-020 The block SHALL perform no arithmetic; result is Product passed through unmodified.

Reset
REQ-021 rst=1 SHALL immediately force:
- state = IDLE, priority pointer = 0;
- load, gnt0, gnt1, done, done_id, timeout, result, Multiplier, Multiplicand = 0.
REQ-022 Reset during LOAD/WAIT/RESP SHALL abort the operation with no done pulse; the first request after rst falls is arbitrated normally.

Verification
REQ-023 Single op: req0, a0=-3, b0=7; model returns Product=8'hEB with booth_dv on the 2nd WAIT cycle -> gnt0 pulse, load one cycle, done with result=8'hEB, done_id=0, timeout=0.
REQ-024 Contention: req0 and req1 raised together, a1=-5, b1=3 -> requester 0 served first; then gnt1 and done with result=8'hF1, done_id=1; the pointer then favours requester 0.
REQ-025 Stale flag: booth_dv=1 on the first WAIT cycle only, then 0 -> not captured; after 16 WAIT cycles, done with timeout=1, result=0.
REQ-026 Reset mid-op: rst pulsed during WAIT -> load=0 and done=0 immediately; no done follows; next req1 is granted within 2 cycles of rst falling.
REQ-027 Dropped request: req1 high for one cycle while busy, low before return to IDLE -> no gnt1, no done for requester 1.
REQ-028 Back-to-back: both requesters hold req continuously for 6 operations -> grants alternate 0,1,0,1,0,1; exactly one done per grant; Multiplier/Multiplicand stable through each LOAD/WAIT.

Source files
------------

// File: rtl/booth_arbiter.sv
// Two-requester round-robin front end for a shared, externally clocked Booth multiplier.
// Latches the winner's operands, strobes load, and waits for booth_dv with a bounded timeout.
module booth_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] result,
  output logic               timeout,
  output logic               load,
  output logic [WIDTH-1:0]   Multiplier,
  output logic [WIDTH-1:0]   Multiplicand,
  input  logic [2*WIDTH-1:0] Product,
  input  logic               booth_dv
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               load_q, load_d;
  logic               done_q, done_d, done_id_q, done_id_d;
  logic               timeout_q, timeout_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, mcand_q, mcand_d;
  logic               win;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    load_d    = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    win       = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // Pointer only breaks ties; a lone requester always wins.
          win      = (req0 && req1) ? prio_q : req1;
          owner_d  = win;
          gnt0_d   = ~win;
          gnt1_d   = win;
          mplier_d = win ? a1 : a0;
          mcand_d  = win ? b1 : b0;
          load_d   = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A booth_dv seen on the first WAIT cycle may be left over from a previous op.
        if ((cnt_q != '0) && booth_dv) begin
          result_d  = Product;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          result_d  = '0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        prio_d  = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      load_q    <= load_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign load         = load_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign timeout      = timeout_q;
  assign result       = result_q;
  assign Multiplier   = mplier_q;
  assign Multiplicand = mcand_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: directed vector table, hand-written corner sequences and a
// randomized run scored against a round-robin/latency model of the arbiter.
module tb_booth_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned TO = 16;

  logic           clk, rst, req0, req1, gnt0, gnt1, done, done_id, timeout, load, booth_dv;
  logic [W-1:0]   a0, a1, b0, b1, mplier, mcand;
  logic [2*W-1:0] result, product;

  int n_checks = 0;
  int n_fail   = 0;
  bit ptr;

  typedef struct {
    bit             r0, r1;
    logic [W-1:0]   x0, y0, x1, y1;
    int             k;
    bit             stale;
    bit             id;
    logic [2*W-1:0] res;
    bit             to;
  } vec_t;

  vec_t vecs[7];

  booth_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .done_id(done_id), .result(result),
    .timeout(timeout), .load(load), .Multiplier(mplier), .Multiplicand(mcand),
    .Product(product), .booth_dv(booth_dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] sx, sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
  endfunction

  // Starts in the LOAD cycle; ends in the IDLE cycle following the done pulse.
  // k is the WAIT cycle (1-based) on which the multiplier model pulses booth_dv.
  task automatic finish_op(input bit w, input logic [W-1:0] mx, input logic [W-1:0] my,
                           input int k, input bit stale, input logic [2*W-1:0] exp_res,
                           input bit exp_to);
    int jexp;
    logic [2*W-1:0] prod;
    prod     = smul(mx, my);
    jexp     = (k >= 2 && k <= int'(TO)) ? k : int'(TO);
    booth_dv = 1'b0;
    product  = (2*W)'($urandom);
    tick();
    check("load_one_cycle", 64'(load), 64'(1'b0));
    check("gnt_one_cycle", 64'({gnt0, gnt1}), 64'(2'b00));
    for (int j = 1; j <= jexp; j++) begin
      booth_dv = (j == k) || (stale && j == 1);
      product  = (j == k) ? prod : (2*W)'($urandom);
      tick();
      booth_dv = 1'b0;
      check("mplier_stable", 64'(mplier), 64'(mx));
      check("mcand_stable", 64'(mcand), 64'(my));
      if (j < jexp) check("done_early", 64'(done), 64'(1'b0));
    end
    check("done", 64'(done), 64'(1'b1));
    check("done_id", 64'(done_id), 64'(w));
    check("result", 64'(result), 64'(exp_res));
    check("timeout", 64'(timeout), 64'(exp_to));
    tick();
    check("done_pulse", 64'(done), 64'(1'b0));
    check("timeout_clear", 64'(timeout), 64'(1'b0));
    check("result_hold", 64'(result), 64'(exp_res));
    check("done_id_hold", 64'(done_id), 64'(w));
    check("idle_no_gnt", 64'({gnt0, gnt1}), 64'(2'b00));
    ptr = ~w;
  endtask

  task automatic run_op(input bit r0, input bit r1, input logic [W-1:0] x0,
                        input logic [W-1:0] y0, input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input int k, input bit stale, input bit hold, input bit exp_id,
                        input logic [2*W-1:0] exp_res, input bit exp_to);
    logic [W-1:0] mx, my;
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    tick();
    mx = exp_id ? x1 : x0;
    my = exp_id ? y1 : y0;
    check("gnt0", 64'(gnt0), 64'(!exp_id));
    check("gnt1", 64'(gnt1), 64'(exp_id));
    check("load", 64'(load), 64'(1'b1));
    check("mplier_latch", 64'(mplier), 64'(mx));
    check("mcand_latch", 64'(mcand), 64'(my));
    if (!hold) begin
      // Winner drops its request and its operand bus is no longer guaranteed.
      if (exp_id) begin req1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom); end
      else        begin req0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom); end
    end
    finish_op(exp_id, mx, my, k, stale, exp_res, exp_to);
  endtask

  initial begin
    bit r0, r1, w, st, hd, to, got;
    int pat, k;
    logic [W-1:0] x0, y0, x1, y1;
    logic [2*W-1:0] p;

    vecs[0] = '{1'b1, 1'b1, 4'hD, 4'h7, 4'hB, 4'h3, 2,  1'b0, 1'b0, 8'hEB, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'hD, 4'h7, 4'hB, 4'h3, 2,  1'b0, 1'b1, 8'hF1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'h7, 4'h7, 4'h8, 4'h8, 5,  1'b1, 1'b0, 8'h31, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'h7, 4'h7, 4'h8, 4'h8, 16, 1'b0, 1'b1, 8'h40, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 4'h8, 4'h7, 4'h1, 4'h1, 1,  1'b1, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'h8, 4'h7, 4'h1, 4'h1, 17, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h7, 4'h8, 3,  1'b0, 1'b1, 8'hC8, 1'b0};

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; booth_dv = 1'b0; product = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; ptr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_ctrl", 64'({gnt0, gnt1, load, done, done_id, timeout}), 64'(6'b0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_operands", 64'({mplier, mcand}), 64'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_quiet", 64'({gnt0, gnt1, load, done}), 64'(4'b0));

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].r0, vecs[i].r1, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
             vecs[i].k, vecs[i].stale, 1'b0, vecs[i].id, vecs[i].res, vecs[i].to);

    // Reset in the middle of WAIT aborts silently; the next request is served normally.
    req0 = 1'b1; req1 = 1'b0; a0 = 4'h5; b0 = 4'h6;
    tick();
    check("rst_op_gnt", 64'(gnt0), 64'(1'b1));
    req0 = 1'b0;
    tick(); tick();
    #2 rst = 1'b1; booth_dv = 1'b1; product = 8'h1E;
    #1;
    check("rst_mid_ctrl", 64'({load, done, timeout, done_id, gnt0, gnt1}), 64'(6'b0));
    check("rst_mid_result", 64'(result), 64'(0));
    check("rst_mid_operands", 64'({mplier, mcand}), 64'(0));
    tick();
    check("rst_hold_done", 64'(done), 64'(1'b0));
    tick();
    rst = 1'b0; booth_dv = 1'b0; ptr = 1'b0;
    req1 = 1'b1; a1 = 4'h2; b1 = 4'h9;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      tick();
      check("rst_no_done", 64'(done), 64'(1'b0));
      if (gnt1) got = 1'b1;
    end
    check("rst_regrant", 64'(got), 64'(1'b1));
    req1 = 1'b0;
    finish_op(1'b1, 4'h2, 4'h9, 2, 1'b0, 8'hF2, 1'b0);

    // A one-cycle req1 while busy is gone before IDLE and must never be served.
    req0 = 1'b1; a0 = 4'h3; b0 = 4'h5;
    tick();
    check("drop_gnt0", 64'(gnt0), 64'(1'b1));
    req0 = 1'b0; req1 = 1'b1;
    fork
      begin @(posedge clk); #1 req1 = 1'b0; end
    join_none
    finish_op(1'b0, 4'h3, 4'h5, 2, 1'b0, 8'h0F, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("drop_no_gnt", 64'({gnt0, gnt1}), 64'(2'b00));
      check("drop_no_done", 64'(done), 64'(1'b0));
    end

    // Both requesters held continuously: grants alternate starting from requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0; ptr = 1'b0;
    for (int i = 0; i < 6; i++)
      run_op(1'b1, 1'b1, 4'h2, 4'hD, 4'h9, 4'h5, 2 + i, 1'b0, 1'b1, bit'(i % 2),
             (i % 2 == 1) ? 8'hDD : 8'hFA, 1'b0);

    for (int i = 0; i < 40; i++) begin
      pat = int'($urandom_range(1, 3));
      r0  = pat[0];
      r1  = pat[1];
      x0  = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
      k   = int'($urandom_range(1, TO + 2));
      st  = 1'($urandom);
      hd  = 1'($urandom);
      w   = (r0 && r1) ? ptr : r1;
      to  = !(k >= 2 && k <= int'(TO));
      p   = to ? '0 : (w ? smul(x1, y1) : smul(x0, y0));
      run_op(r0, r1, x0, y0, x1, y1, k, st, hd, w, p, to);
    end
    req0 = 1'b0; req1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
